alu_op_sequencer: RTL and testbench

Control front-end for the 32-bit ALU. It accepts one operation request at a time through a start/done handshake and registers the operands and the 3-bit result-mux select for the ALU datapath. Single-cycle ops (AND, OR, XOR, NOR, SLT, ADD, SUB) are handed straight to the combinational ALU. MOD is computed internally by a multi-cycle restoring shift-subtract remainder engine, which frees the combinational datapath from a full-width modulo array.

---
 rtl/alu_op_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Control front-end for the 32-bit ALU: start/done handshake, registered operands and
// result-mux select, and a multi-cycle restoring remainder engine for MOD.
module alu_op_sequencer #(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   opcode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [2:0]   alu_sel,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] mod_result,
  output logic         div_zero
);

  localparam logic [2:0]    OpMod   = 3'b111;
  localparam logic [CW-1:0] CntLast = CW'(W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StModIter,
    StDone
  } state_e;

  state_e       state_q, state_d;
  logic [2:0]   alu_sel_q, alu_sel_d;
  logic [W-1:0] op_a_q, op_a_d;
  logic [W-1:0] op_b_q, op_b_d;
  logic [W-1:0] mod_result_q, mod_result_d;
  logic         div_zero_q, div_zero_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]   rem_q, rem_d;
  logic [W-1:0] dvd_q, dvd_d;

  // Remainder stays below op_b, so rem_q[W] is always zero; only the low W bits shift in.
  logic [W:0]   trial;
  logic [W:0]   trial_diff;
  logic         trial_ge;
  logic [W:0]   rem_step;

  always_comb begin
    trial      = {rem_q[W-1:0], dvd_q[W-1]};
    trial_ge   = (trial >= {1'b0, op_b_q});
    trial_diff = trial - {1'b0, op_b_q};
    rem_step   = trial_ge ? trial_diff : trial;
  end

  always_comb begin
    state_d      = state_q;
    alu_sel_d    = alu_sel_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    mod_result_d = mod_result_q;
    div_zero_d   = div_zero_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    dvd_d        = dvd_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_a_d     = a;
          op_b_d     = b;
          alu_sel_d  = opcode;
          div_zero_d = 1'b0;
          if (opcode != OpMod) begin
            state_d = StExec;
          end else if (b == '0) begin
            // Divide by zero: report the dividend unchanged and flag it.
            state_d      = StExec;
            div_zero_d   = 1'b1;
            mod_result_d = a;
          end else begin
            state_d = StModIter;
            rem_d   = '0;
            dvd_d   = a;
            cnt_d   = '0;
          end
        end
      end
      StExec: begin
        state_d = StDone;
      end
      StModIter: begin
        dvd_d = dvd_q << 1;
        rem_d = rem_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CntLast) begin
          mod_result_d = rem_step[W-1:0];
          state_d      = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      alu_sel_q    <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      mod_result_q <= '0;
      div_zero_q   <= 1'b0;
      cnt_q        <= '0;
      rem_q        <= '0;
      dvd_q        <= '0;
    end else begin
      state_q      <= state_d;
      alu_sel_q    <= alu_sel_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      mod_result_q <= mod_result_d;
      div_zero_q   <= div_zero_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      dvd_q        <= dvd_d;
    end
  end

  always_comb begin
    alu_sel    = alu_sel_q;
    op_a       = op_a_q;
    op_b       = op_b_q;
    mod_result = mod_result_q;
    div_zero   = div_zero_q;
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed requests push expected completions,
// a negedge monitor pops and checks them whenever done is seen.
module tb_alu_op_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   alu_sel;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] mod_result;
  logic         div_zero;

  alu_op_sequencer #(.W(W), .CW(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .alu_sel   (alu_sel),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .mod_result(mod_result),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]   sel;
    logic [W-1:0] oa;
    logic [W-1:0] ob;
    logic [W-1:0] mr;
    logic         dz;
    int           done_cyc;
    int           tag;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_done: got done=1 at cycle %0d, expected no pending request", cyc);
      end else begin
        e = q.pop_front();
        check($sformatf("req%0d_done_cycle", e.tag), 64'(cyc), 64'(e.done_cyc));
        check($sformatf("req%0d_alu_sel", e.tag), 64'(alu_sel), 64'(e.sel));
        check($sformatf("req%0d_op_a", e.tag), 64'(op_a), 64'(e.oa));
        check($sformatf("req%0d_op_b", e.tag), 64'(op_b), 64'(e.ob));
        check($sformatf("req%0d_div_zero", e.tag), 64'(div_zero), 64'(e.dz));
        check($sformatf("req%0d_mod_result", e.tag), 64'(mod_result), 64'(e.mr));
        check($sformatf("req%0d_busy_at_done", e.tag), 64'(busy), 64'd1);
      end
    end
  end

  task automatic wait_idle();
    int i = 0;
    @(negedge clk);
    while (busy && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=1 after 100 cycles, expected busy=0");
    end
  endtask

  // Issue from a negedge while idle; returns the accept edge index.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit push, input logic [W-1:0] mr, input logic dz, input int tag,
                       output int n);
    exp_t e;
    opcode = op;
    a      = av;
    b      = bv;
    start  = 1'b1;
    @(posedge clk);
    #1;
    n     = cyc;
    start = 1'b0;
    a     = ~av;
    b     = 32'hFFFF_FFFF;
    check($sformatf("req%0d_busy_after_accept", tag), 64'(busy), 64'd1);
    check($sformatf("req%0d_latched_op_a", tag), 64'(op_a), 64'(av));
    check($sformatf("req%0d_latched_op_b", tag), 64'(op_b), 64'(bv));
    check($sformatf("req%0d_latched_sel", tag), 64'(alu_sel), 64'(op));
    if (push) begin
      e.sel      = op;
      e.oa       = av;
      e.ob       = bv;
      e.mr       = mr;
      e.dz       = dz;
      e.done_cyc = n + ((op == 3'b111 && bv != 0) ? W : 1);
      e.tag      = tag;
      q.push_back(e);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_alu_sel"}, 64'(alu_sel), 64'd0);
    check({nm, "_op_a"}, 64'(op_a), 64'd0);
    check({nm, "_op_b"}, 64'(op_b), 64'd0);
    check({nm, "_busy"}, 64'(busy), 64'd0);
    check({nm, "_done"}, 64'(done), 64'd0);
    check({nm, "_mod_result"}, 64'(mod_result), 64'd0);
    check({nm, "_div_zero"}, 64'(div_zero), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n2;
    reset  = 1'b1;
    start  = 1'b1;
    opcode = 3'b101;
    a      = 32'h1;
    b      = 32'h2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    start = 1'b0;

    // Single-cycle op.
    issue(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'h0, 1'b0, 1, n);
    while (cyc < n + 2) @(negedge clk);
    check("req1_busy_after_done", 64'(busy), 64'd0);

    wait_idle();
    issue(3'b111, 32'd100, 32'd7, 1, 32'd2, 1'b0, 2, n);
    wait_idle();
    issue(3'b111, 32'hFFFF_FFFF, 32'h10, 1, 32'hF, 1'b0, 3, n);
    wait_idle();
    issue(3'b111, 32'd5, 32'd9, 1, 32'd5, 1'b0, 4, n);
    wait_idle();
    issue(3'b111, 32'h1234, 32'h0, 1, 32'h1234, 1'b1, 5, n);
    wait_idle();
    issue(3'b101, 32'd3, 32'd4, 1, 32'h1234, 1'b0, 6, n);

    // Start pulses during MOD and during its DONE cycle must be ignored.
    wait_idle();
    issue(3'b111, 32'hDEAD_BEEF, 32'h100, 1, 32'hEF, 1'b0, 7, n);
    while (cyc < n + 4) @(negedge clk);
    opcode = 3'b101;
    a      = 32'h1;
    b      = 32'h2;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < n + W) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ignored_start_busy", 64'(busy), 64'd0);
    check("ignored_start_op_a", 64'(op_a), 64'hDEAD_BEEF);
    check("ignored_start_op_b", 64'(op_b), 64'h100);
    check("ignored_start_sel", 64'(alu_sel), 64'd7);
    check("ignored_start_mod_result", 64'(mod_result), 64'hEF);

    // Reset mid-MOD aborts without a done pulse.
    wait_idle();
    issue(3'b111, 32'd1000, 32'd3, 0, 32'h0, 1'b0, 8, n);
    while (cyc < n + 9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("mid_mod_reset");
    repeat (40) @(negedge clk);
    check("mid_mod_reset_idle", 64'(busy), 64'd0);
    issue(3'b111, 32'd10, 32'd4, 1, 32'd2, 1'b0, 9, n);

    // Back-to-back with start held high.
    wait_idle();
    opcode = 3'b110;
    a      = 32'd50;
    b      = 32'd8;
    start  = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    q.push_back('{sel: 3'b110, oa: 32'd50, ob: 32'd8, mr: 32'd2, dz: 1'b0,
                  done_cyc: n + 1, tag: 10});
    opcode = 3'b100;
    a      = 32'd3;
    b      = 32'h8000_0000;
    n2     = n + 3;
    q.push_back('{sel: 3'b100, oa: 32'd3, ob: 32'h8000_0000, mr: 32'd2, dz: 1'b0,
                  done_cyc: n2 + 1, tag: 11});
    while (cyc < n + 2) @(negedge clk);
    check("b2b_idle_gap", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_accepted", 64'(busy), 64'd1);
    wait_idle();

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
